line_state_array: RTL and testbench
===================================

Name: line_state_array

Overview:
- Per-(set, way) line-state store for the cache core: one valid bit plus a per-word dirty mask.
- Replaces the single-bit dirty array with word-granular dirty tracking, explicit state-update opcodes, and a built-in flush engine.
- The flush engine walks every entry and hands each dirty line to the write-back controller over a valid/ready handshake.
- Sits beside the tag array; it is driven by the cache controller and feeds the AXI write-back path.

Parameters:
- ASSOC, 8, number of ways per set; power of two, ≥2.
- INDEX_SIZE, 7, set index width; SETS = 2**INDEX_SIZE.
- WORDS, 16, words per line, which is the dirty-mask width; ≥1.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous active-high reset.
- index  input  INDEX_SIZE  set addressed by the lookup/op port.
- way  input  $clog2(ASSOC)  way addressed by the lookup/op port, taken from the tag array.
- op  input  3  update opcode, applied at the clock edge.
- wmask  input  WORDS  word mask used by WRITE_HIT/FILL.
- valid_o  output  1  valid bit of [index][way], combinational.
- dirty_o  output  1  valid_o AND (|dirty_mask_o), combinational.
- dirty_mask_o  output  WORDS  dirty mask of [index][way], combinational.
- flush_start  input  1  single-cycle request to begin a flush.
- flush_busy  output  1  high from the cycle after an accepted flush_start until the DONE cycle, inclusive.
- wb_valid  output  1  dirty line offered for write-back.
- wb_index  output  INDEX_SIZE  set of the offered line.
- wb_way  output  $clog2(ASSOC)  way of the offered line.
- wb_mask  output  WORDS  dirty words of the offered line.
- wb_ready  input  1  write-back controller accepts the offer.
- flush_done  output  1  one-cycle pulse when a flush completes.

Behaviour:
- Clock, reset and read port:
  - One clock domain: clk.
  - Reset is synchronous, active-high, on rst.
  - Reset clears every valid bit and dirty mask and returns the FSM to IDLE.
  - After reset, all outputs read 0.
  - Read outputs are combinational from [index][way] and show state before the current edge's update. There is no write-to-read bypass in the same cycle.
- Opcodes (act on [index][way]):
  - 000 NOP.
  - 001 WRITE_HIT: mask |= wmask. Ignored if the entry is invalid.
  - 010 FILL: valid=1, mask=wmask. wmask=0 is a clean fill; nonzero marks store-allocate words.
  - 011 CLEAN: mask=0. Valid is unchanged.
  - 100 INVALIDATE: valid=0, mask=0.
  - 101 INV_ALL: every entry is cleared in one cycle. index and way are ignored.
  - 110 and 111: NOP.
- Interaction with the flush engine:
  - While flush_busy=1, op is ignored (treated as NOP). The controller must stall.
  - flush_start is accepted only in IDLE. If op and flush_start arrive in the same IDLE cycle, the op is applied and the flush begins.
- Flush FSM, states IDLE, SCAN, OFFER, DONE:
  - IDLE: flush_start=1 → SCAN with scan pointer {set=0, way=0}.
  - SCAN: examine one entry per cycle at the pointer.
    - If the entry is valid with a nonzero mask → OFFER.
    - Otherwise advance the pointer, way-fastest then set.
    - After the last entry (SETS-1, ASSOC-1) is examined → DONE.
  - OFFER:
    - wb_valid=1; wb_index, wb_way and wb_mask are registered and held stable until the handshake.
    - Handshake (wb_valid & wb_ready): that entry's mask clears to 0 and valid stays 1 on the same edge.
    - After the handshake, advance the pointer and return to SCAN, or go to DONE if it was the last entry.
    - wb_valid must never drop without a handshake.
  - DONE: flush_done=1 for one cycle → IDLE.
- Flush outputs:
  - wb_valid, wb_index, wb_way and wb_mask are 0 outside OFFER.
  - flush_done is 0 outside DONE.
- Latency: a flush with no dirty lines takes exactly SETS*ASSOC SCAN cycles plus 1 DONE cycle.
- Reset mid-flush: the FSM returns to IDLE and arrays clear. No flush_done pulse and no further wb_valid.
- Pointer arithmetic: the way counter wraps from ASSOC-1 to 0 and increments set. Set SETS-1 with way ASSOC-1 is terminal; there is no wrap back to 0.

Test Plan:
- rst=1 for 1 cycle, then sweep every index/way → valid_o=0, dirty_mask_o=0, flush_busy=0, wb_valid=0.
- FILL idx=5 way=3 wmask=0; WRITE_HIT wmask=0x0011; WRITE_HIT wmask=0x0100 → dirty_mask_o=0x0111, dirty_o=1. CLEAN → mask 0x0000, valid_o=1. WRITE_HIT on invalid idx=6 way=0 → stays 0.
- FILL idx=2 way=1 wmask=0x8000; INVALIDATE → valid_o=0, mask 0. Then INV_ALL after several fills → all entries 0.
- Dirty lines at (0,7) and (127,0), mask 0xFFFF; flush_start; wb_ready held low 5 cycles per offer → two offers in that order, fields stable while waiting. flush_done pulses exactly once; both masks read 0 with valid_o=1.
- Empty array, flush_start (INDEX_SIZE=7, ASSOC=8) → flush_done exactly 1025 cycles after the start edge. op=FILL issued while busy has no effect.
- Assert rst during OFFER → wb_valid=0 and flush_busy=0 next cycle, no flush_done, all entries cleared.

Source files
------------

// File: rtl/line_state_array.sv
// Per-(set, way) line state: valid bit plus per-word dirty mask, with
// update opcodes on the lookup port and a flush engine that walks every
// entry and offers dirty lines to the write-back path.
module line_state_array #(
  parameter int ASSOC      = 8,
  parameter int INDEX_SIZE = 7,
  parameter int WORDS      = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [INDEX_SIZE-1:0]    index,
  input  logic [$clog2(ASSOC)-1:0] way,
  input  logic [2:0]               op,
  input  logic [WORDS-1:0]         wmask,
  output logic                     valid_o,
  output logic                     dirty_o,
  output logic [WORDS-1:0]         dirty_mask_o,
  input  logic                     flush_start,
  output logic                     flush_busy,
  output logic                     wb_valid,
  output logic [INDEX_SIZE-1:0]    wb_index,
  output logic [$clog2(ASSOC)-1:0] wb_way,
  output logic [WORDS-1:0]         wb_mask,
  input  logic                     wb_ready,
  output logic                     flush_done
);
  localparam int SETS  = 2 ** INDEX_SIZE;
  localparam int WAY_W = $clog2(ASSOC);

  localparam logic [2:0] OP_WRITE_HIT  = 3'b001;
  localparam logic [2:0] OP_FILL       = 3'b010;
  localparam logic [2:0] OP_CLEAN      = 3'b011;
  localparam logic [2:0] OP_INVALIDATE = 3'b100;
  localparam logic [2:0] OP_INV_ALL    = 3'b101;

  typedef enum logic [1:0] {IDLE, SCAN, OFFER, DONE} state_t;

  logic [SETS-1:0][ASSOC-1:0]             valid_q;
  logic [SETS-1:0][ASSOC-1:0][WORDS-1:0]  mask_q;

  state_t                  state_q, state_d;
  logic [INDEX_SIZE-1:0]   ptr_set;
  logic [WAY_W-1:0]        ptr_way;
  logic [INDEX_SIZE-1:0]   wb_index_q;
  logic [WAY_W-1:0]        wb_way_q;
  logic [WORDS-1:0]        wb_mask_q;

  logic op_en, start, hs, ptr_last, ptr_dirty, adv, load_wb;

  // Ops are only honoured in IDLE; the controller stalls while flushing.
  assign op_en     = (state_q == IDLE);
  assign start     = op_en & flush_start;
  assign hs        = (state_q == OFFER) & wb_ready;
  // Pointer is {set, way}, so all-ones is the terminal entry.
  assign ptr_last  = &{ptr_set, ptr_way};
  assign ptr_dirty = valid_q[ptr_set][ptr_way] & (|mask_q[ptr_set][ptr_way]);

  // State array: opcode updates from the lookup port, mask clear on handshake.
  always_ff @(posedge clk) begin
    if (rst || (op_en && op == OP_INV_ALL)) begin
      valid_q <= '0;
      mask_q  <= '0;
    end else begin
      if (op_en) begin
        case (op)
          OP_WRITE_HIT:
            if (valid_q[index][way])
              mask_q[index][way] <= mask_q[index][way] | wmask;
          OP_FILL: begin
            valid_q[index][way] <= 1'b1;
            mask_q[index][way]  <= wmask;
          end
          OP_CLEAN:
            mask_q[index][way] <= '0;
          OP_INVALIDATE: begin
            valid_q[index][way] <= 1'b0;
            mask_q[index][way]  <= '0;
          end
          default: ;
        endcase
      end
      // Ops and handshakes never coincide: ops are gated off outside IDLE.
      if (hs) mask_q[ptr_set][ptr_way] <= '0;
    end
  end

  // Flush FSM next-state and pointer/offer control.
  always_comb begin
    state_d = state_q;
    adv     = 1'b0;
    load_wb = 1'b0;
    case (state_q)
      IDLE:  if (flush_start) state_d = SCAN;
      SCAN: begin
        if (ptr_dirty) begin
          state_d = OFFER;
          load_wb = 1'b1;
        end else if (ptr_last) begin
          state_d = DONE;
        end else begin
          adv = 1'b1;
        end
      end
      OFFER: begin
        if (wb_ready) begin
          if (ptr_last) begin
            state_d = DONE;
          end else begin
            state_d = SCAN;
            adv     = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Flush FSM state, scan pointer and the held write-back offer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_set    <= '0;
      ptr_way    <= '0;
      wb_index_q <= '0;
      wb_way_q   <= '0;
      wb_mask_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start)
        {ptr_set, ptr_way} <= '0;
      else if (adv)
        {ptr_set, ptr_way} <= {ptr_set, ptr_way} + 1'b1;
      if (load_wb) begin
        wb_index_q <= ptr_set;
        wb_way_q   <= ptr_way;
        wb_mask_q  <= mask_q[ptr_set][ptr_way];
      end
    end
  end

  assign valid_o      = valid_q[index][way];
  assign dirty_mask_o = mask_q[index][way];
  assign dirty_o      = valid_o & (|dirty_mask_o);

  assign flush_busy = (state_q != IDLE);
  assign flush_done = (state_q == DONE);
  assign wb_valid   = (state_q == OFFER);
  assign wb_index   = wb_valid ? wb_index_q : '0;
  assign wb_way     = wb_valid ? wb_way_q   : '0;
  assign wb_mask    = wb_valid ? wb_mask_q  : '0;
endmodule

// File: tb/tb_line_state_array.sv
// Bench for line_state_array: directed steps plus random op traffic,
// checked against an array model of valid bits and dirty masks.
module tb_line_state_array;
  localparam int ASSOC = 8, INDEX_SIZE = 7, WORDS = 16, SETS = 128;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [INDEX_SIZE-1:0] index;
  logic [2:0]            way;
  logic [2:0]            op;
  logic [WORDS-1:0]      wmask;
  logic                  valid_o, dirty_o;
  logic [WORDS-1:0]      dirty_mask_o;
  logic                  flush_start, flush_busy, wb_valid, wb_ready, flush_done;
  logic [INDEX_SIZE-1:0] wb_index;
  logic [2:0]            wb_way;
  logic [WORDS-1:0]      wb_mask;

  always #5 clk = ~clk;

  line_state_array #(.ASSOC(ASSOC), .INDEX_SIZE(INDEX_SIZE), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .index(index), .way(way), .op(op), .wmask(wmask),
    .valid_o(valid_o), .dirty_o(dirty_o), .dirty_mask_o(dirty_mask_o),
    .flush_start(flush_start), .flush_busy(flush_busy),
    .wb_valid(wb_valid), .wb_index(wb_index), .wb_way(wb_way), .wb_mask(wb_mask),
    .wb_ready(wb_ready), .flush_done(flush_done)
  );

  bit               mv [SETS][ASSOC];
  logic [WORDS-1:0] mm [SETS][ASSOC];
  int vec = 0, miss = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic model_clear;
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < ASSOC; w++) begin mv[s][w] = 1'b0; mm[s][w] = '0; end
  endtask

  task automatic model_op(input logic [2:0] o, input int s, input int w, input logic [WORDS-1:0] m);
    case (o)
      3'd1: if (mv[s][w]) mm[s][w] = mm[s][w] | m;
      3'd2: begin mv[s][w] = 1'b1; mm[s][w] = m; end
      3'd3: mm[s][w] = '0;
      3'd4: begin mv[s][w] = 1'b0; mm[s][w] = '0; end
      3'd5: model_clear();
      default: ;
    endcase
  endtask

  task automatic do_op(input logic [2:0] o, input int s, input int w, input logic [WORDS-1:0] m);
    op = o; index = INDEX_SIZE'(s); way = 3'(w); wmask = m;
    tick();
    model_op(o, s, w, m);
    op = 3'd0; wmask = '0;
  endtask

  task automatic rd(input int s, input int w, input string tag);
    index = INDEX_SIZE'(s); way = 3'(w); #1;
    chk({tag, "_valid"}, valid_o, mv[s][w]);
    chk({tag, "_mask"}, dirty_mask_o, mm[s][w]);
    chk({tag, "_dirty"}, dirty_o, (mv[s][w] && mm[s][w] != 0));
  endtask

  // Flush with an op issued together with flush_start; hold<0 means random ready delay.
  task automatic run_flush(input logic [2:0] co_op, input int co_s, input int co_w,
                           input logic [WORDS-1:0] co_m, input int hold);
    int qs[$]; int qw[$]; int cyc; int h;
    op = co_op; index = INDEX_SIZE'(co_s); way = 3'(co_w); wmask = co_m; flush_start = 1'b1;
    tick();
    model_op(co_op, co_s, co_w, co_m);
    op = 3'd0; wmask = '0; flush_start = 1'b0;
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < ASSOC; w++)
        if (mv[s][w] && mm[s][w] != 0) begin qs.push_back(s); qw.push_back(w); end
    chk("flush_busy_on", flush_busy, 1);
    cyc = 0;
    foreach (qs[i]) begin
      while (!wb_valid && !flush_done && cyc < 3000) begin
        chk("idle_wb_mask", wb_mask, 0);
        tick(); cyc++;
      end
      chk("offer_valid", wb_valid, 1);
      if (!wb_valid) break;
      chk("offer_index", wb_index, qs[i]);
      chk("offer_way", wb_way, qw[i]);
      chk("offer_mask", wb_mask, mm[qs[i]][qw[i]]);
      h = (hold < 0) ? int'($urandom_range(0, 3)) : hold;
      repeat (h) begin
        tick(); cyc++;
        chk("offer_hold", {wb_valid, wb_index, wb_way, wb_mask},
            {1'b1, INDEX_SIZE'(qs[i]), 3'(qw[i]), mm[qs[i]][qw[i]]});
      end
      wb_ready = 1'b1;
      tick(); cyc++;
      wb_ready = 1'b0;
      mm[qs[i]][qw[i]] = '0;
    end
    while (!flush_done && cyc < 3000) begin
      chk("no_extra_offer", wb_valid, 0);
      tick(); cyc++;
    end
    chk("flush_done", flush_done, 1);
    tick();
    chk("done_pulse_once", flush_done, 0);
    chk("flush_idle", flush_busy, 0);
  endtask

  initial begin
    int n, s, w;
    logic [2:0] o;
    rst = 1'b1; index = '0; way = '0; op = '0; wmask = '0;
    flush_start = 1'b0; wb_ready = 1'b0;
    tick();
    rst = 1'b0;
    model_clear();

    // Reset state
    chk("rst_busy", flush_busy, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_done", flush_done, 0);
    for (int si = 0; si < SETS; si++)
      for (int wi = 0; wi < ASSOC; wi++) rd(si, wi, "rst_sweep");

    // Fill / write-hit accumulation / clean / write-hit on invalid
    do_op(3'd2, 5, 3, 16'h0000);
    do_op(3'd1, 5, 3, 16'h0011);
    do_op(3'd1, 5, 3, 16'h0100);
    rd(5, 3, "wh_accum");
    chk("wh_mask_const", dirty_mask_o, 16'h0111);
    chk("wh_dirty_const", dirty_o, 1);
    do_op(3'd3, 5, 3, 16'h0000);
    rd(5, 3, "clean");
    chk("clean_valid_const", valid_o, 1);
    chk("clean_mask_const", dirty_mask_o, 0);
    do_op(3'd1, 6, 0, 16'hFFFF);
    rd(6, 0, "wh_invalid");
    chk("wh_invalid_const", {valid_o, dirty_mask_o}, 0);

    // Invalidate, then INV_ALL after several fills
    do_op(3'd2, 2, 1, 16'h8000);
    do_op(3'd4, 2, 1, 16'h0000);
    rd(2, 1, "inval");
    chk("inval_const", {valid_o, dirty_mask_o}, 0);
    do_op(3'd2, 10, 4, 16'h0001);
    do_op(3'd2, 99, 7, 16'h0003);
    do_op(3'd2, 0, 0, 16'h0000);
    do_op(3'd5, 33, 3, 16'h0000);
    for (int si = 0; si < SETS; si++)
      for (int wi = 0; wi < ASSOC; wi++) rd(si, wi, "inv_all");

    // Two dirty lines at the scan extremes, slow ready; second fill shares the start cycle
    do_op(3'd2, 0, 7, 16'hFFFF);
    run_flush(3'd2, 127, 0, 16'hFFFF, 5);
    rd(0, 7, "post_flush_a");
    chk("post_flush_a_const", {valid_o, dirty_mask_o}, {1'b1, 16'h0});
    rd(127, 0, "post_flush_b");
    chk("post_flush_b_const", {valid_o, dirty_mask_o}, {1'b1, 16'h0});

    // Empty flush latency, and an op issued while busy is dropped
    do_op(3'd5, 0, 0, 16'h0);
    flush_start = 1'b1;
    tick();
    flush_start = 1'b0;
    n = 1;
    while (!flush_done && n < 1100) begin
      if (n == 10) begin op = 3'd2; index = 7'd9; way = 3'd2; wmask = 16'hABCD; end
      tick(); n++;
      op = 3'd0; wmask = '0;
    end
    chk("empty_latency", n, 1025);
    tick();
    chk("empty_done_once", flush_done, 0);
    rd(9, 2, "busy_fill_ignored");

    // Random op traffic with reads checked before each edge, then flushes
    for (int pass = 0; pass < 2; pass++) begin
      repeat (600) begin
        s = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, SETS - 1)) : int'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) s = 127;
        w = int'($urandom_range(0, ASSOC - 1));
        o = 3'($urandom_range(0, 7));
        if (o == 3'd5 && $urandom_range(0, 31) != 0) o = 3'd1;
        op = o; index = INDEX_SIZE'(s); way = 3'(w); wmask = 16'($urandom);
        if ($urandom_range(0, 3) == 0) wmask = '0;
        #1;
        chk("rand_valid", valid_o, mv[s][w]);
        chk("rand_mask", dirty_mask_o, mm[s][w]);
        chk("rand_dirty", dirty_o, (mv[s][w] && mm[s][w] != 0));
        tick();
        model_op(o, s, w, wmask);
        op = 3'd0;
      end
      run_flush(3'd0, 0, 0, 16'h0, -1);
      for (int si = 0; si < 4; si++)
        for (int wi = 0; wi < ASSOC; wi++) rd(si, wi, "rand_post_flush");
      rd(127, 7, "rand_post_flush_last");
    end

    // Reset while an offer is pending
    do_op(3'd2, 3, 3, 16'h0005);
    flush_start = 1'b1;
    tick();
    flush_start = 1'b0;
    n = 0;
    while (!wb_valid && n < 2000) begin tick(); n++; end
    chk("rst_offer_seen", wb_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    chk("rst_mid_wb_valid", wb_valid, 0);
    chk("rst_mid_busy", flush_busy, 0);
    repeat (20) begin
      chk("rst_mid_no_done", {flush_done, wb_valid}, 0);
      tick();
    end
    for (int si = 0; si < 8; si++)
      for (int wi = 0; wi < ASSOC; wi++) rd(si, wi, "rst_mid_sweep");

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule
